instruction_prefetch_buffer: RTL

- Fetch front-end directly upstream of the combinational text memory.
- Owns the fetch PC and drives the word address to text memory every cycle.
- Captures the returned instruction word, with its PC, into a small FIFO.
- Presents FIFO entries to decode over a valid/ready handshake; a redirect from execute (branch/jump) flushes the FIFO and restarts fetch.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instruction_prefetch_buffer.sv | 80 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end: reset PC default and the
// {pc, inst} entry carried through the prefetch FIFO.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with a flush that empties it
// in one edge. Pointers wrap naturally; the count carries one extra bit.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enq_i,
  input  logic                       deq_i,
  input  logic                       flush_i,
  input  fetch_entry_t               wr_data_i,
  output fetch_entry_t               rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_enq, do_deq;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO may only take a new entry in a cycle that also pops one.
  assign do_deq = deq_i & ~empty_o;
  assign do_enq = enq_i & (~full_o | do_deq);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; validity is tracked entirely by count/pointers.
  always_ff @(posedge clk_i) begin
    if (do_enq && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Fetch front-end: owns the fetch PC, addresses combinational text memory and
// queues {pc, inst} pairs for decode; a redirect flushes and restarts fetch.
module instruction_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int          TEXT_BITS = 16,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [TEXT_BITS-3:0]  text_address,
  input  logic [31:0]           text_q,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  inst_valid,
  output logic [31:0]           inst,
  output logic [31:0]           inst_pc,
  input  logic                  inst_ready,
  output logic                  fetch_misaligned
);

  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic                   misaligned_q, misaligned_d;
  logic                   enq, deq;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] unused_fifo_count;
  fetch_entry_t           wr_entry, head_entry;

  // Upper PC bits alias; memory only sees the text window.
  assign text_address = fetch_pc_q[TEXT_BITS-1:2];

  assign inst_valid = ~fifo_empty;
  assign inst       = head_entry.inst;
  assign inst_pc    = head_entry.pc;
  assign deq        = inst_valid & inst_ready;
  assign enq        = ~redirect_valid & (~fifo_full | deq);

  assign wr_entry.pc   = fetch_pc_q;
  assign wr_entry.inst = text_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    misaligned_d = misaligned_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) misaligned_d = 1'b1;
    end else if (enq) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q   <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign fetch_misaligned = misaligned_q;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .enq_i     (enq),
    .deq_i     (deq),
    .flush_i   (redirect_valid),
    .wr_data_i (wr_entry),
    .rd_data_o (head_entry),
    .count_o   (unused_fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule
